// File: rtl/dsp_mac_pkg.sv
// rtl/dsp_mac_pkg.sv - shared constants for the parametrised MAC pipeline
package dsp_mac_pkg;

    localparam int OP_PRE_EN   = 0;
    localparam int OP_PRE_SUB  = 1;
    localparam int OP_ZSEL_LO  = 2;
    localparam int OP_ZSEL_HI  = 3;
    localparam int OP_POST_SUB = 4;

    localparam logic [1:0] Z_ZERO = 2'd0;
    localparam logic [1:0] Z_C    = 2'd1;
    localparam logic [1:0] Z_P    = 2'd2;

    localparam int LAT = 4;

endpackage

// File: rtl/dsp_mac_pipe_if.sv
// rtl/dsp_mac_pipe_if.sv - operand/result bundle of the MAC pipeline
interface dsp_mac_pipe_if #(
    parameter int AW = 18,
    parameter int BW = 18,
    parameter int PW = 48
);
    logic          CE;
    logic          CLR;
    logic          IN_VALID;
    logic [4:0]    OPMODE;
    logic [AW-1:0] A;
    logic [BW-1:0] B;
    logic [BW-1:0] D;
    logic [PW-1:0] C;
    logic          CARRYIN;
    logic [AW+BW-1:0] M;
    logic [PW-1:0] P;
    logic          CARRYOUT;
    logic          OUT_VALID;
    logic          OVF;

    modport master (
        output CE, CLR, IN_VALID, OPMODE, A, B, D, C, CARRYIN,
        input  M, P, CARRYOUT, OUT_VALID, OVF
    );

    modport slave (
        input  CE, CLR, IN_VALID, OPMODE, A, B, D, C, CARRYIN,
        output M, P, CARRYOUT, OUT_VALID, OVF
    );
endinterface

// File: rtl/dsp_post_add.sv
// rtl/dsp_post_add.sv - Z +/- (M + CARRYIN) with carry-out and optional saturation
module dsp_post_add #(
    parameter int PW     = 48,
    parameter int SAT_EN = 0
) (
    input  logic [PW-1:0] z,
    input  logic [PW-1:0] m,
    input  logic          cin,
    input  logic          sub,
    output logic [PW-1:0] p,
    output logic          carry,
    output logic          ovf
);
    logic signed [PW+1:0] ze;
    logic signed [PW+1:0] me;
    logic signed [PW+1:0] ce;
    logic signed [PW+1:0] sum;
    logic                 ovf_raw;
    logic [PW-1:0]        sat_val;

    always_comb begin
        ze  = {z[PW-1], z[PW-1], z};
        me  = {m[PW-1], m[PW-1], m};
        ce  = {{(PW+1){1'b0}}, cin};
        sum = sub ? (ze - (me + ce)) : (ze + me + ce);
    end

    // Exact signed result: overflow when the top three bits disagree.
    assign ovf_raw = !((sum[PW+1:PW-1] == 3'b000) || (sum[PW+1:PW-1] == 3'b111));
    // Unsigned bit PW differs from the signed result by the two operand sign bits.
    assign carry   = sum[PW] ^ z[PW-1] ^ m[PW-1];
    assign sat_val = sum[PW+1] ? {1'b1, {(PW-1){1'b0}}} : {1'b0, {(PW-1){1'b1}}};

    always_comb begin
        p   = sum[PW-1:0];
        ovf = 1'b0;
        if ((SAT_EN != 0) && ovf_raw) begin
            p   = sat_val;
            ovf = 1'b1;
        end
    end
endmodule

// File: rtl/dsp_mac_pipe.sv
// rtl/dsp_mac_pipe.sv - 4-stage valid-tagged pre-add/multiply/post-add MAC slice
module dsp_mac_pipe #(
    parameter int AW     = 18,
    parameter int BW     = 18,
    parameter int PW     = 48,
    parameter int SAT_EN = 0
) (
    input  logic           CLK,
    input  logic           RST,
    dsp_mac_pipe_if.slave  bus
);
    import dsp_mac_pkg::*;

    localparam int MW = AW + BW;

    if (PW < MW) begin : g_width_check
        $error("dsp_mac_pipe: PW must be at least AW+BW");
    end

    logic [AW-1:0] s1_a;
    logic [BW-1:0] s1_b, s1_d;
    logic [PW-1:0] s1_c;
    logic [4:0]    s1_op;
    logic          s1_cin, s1_v;

    logic [AW-1:0] s2_a;
    logic [BW-1:0] s2_pre;
    logic [PW-1:0] s2_c;
    logic [1:0]    s2_zsel;
    logic          s2_psub, s2_cin, s2_v;

    logic [PW-1:0] s3_c;
    logic [1:0]    s3_zsel;
    logic          s3_psub, s3_cin, s3_v;

    logic [MW-1:0] m_q;
    logic [PW-1:0] p_q;
    logic          co_q, ov_q, ovf_q;

    logic [BW-1:0] pre;
    logic [MW-1:0] prod;
    logic [PW-1:0] m_ext;
    logic [PW-1:0] z;
    logic [PW-1:0] pa_p;
    logic          pa_carry, pa_ovf;

    always_comb begin
        pre = s1_b;
        if (s1_op[OP_PRE_EN]) begin
            pre = s1_op[OP_PRE_SUB] ? (s1_d - s1_b) : (s1_d + s1_b);
        end
    end

    // Both factors widened to MW so the truncated product is the exact signed result.
    assign prod  = $signed({{BW{s2_a[AW-1]}}, s2_a}) * $signed({{AW{s2_pre[BW-1]}}, s2_pre});
    assign m_ext = PW'($signed(m_q));

    always_comb begin
        case (s3_zsel)
            Z_ZERO:  z = '0;
            Z_C:     z = s3_c;
            Z_P:     z = p_q;
            default: z = '0;
        endcase
    end

    dsp_post_add #(.PW(PW), .SAT_EN(SAT_EN)) u_post_add (
        .z     (z),
        .m     (m_ext),
        .cin   (s3_cin),
        .sub   (s3_psub),
        .p     (pa_p),
        .carry (pa_carry),
        .ovf   (pa_ovf)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_a <= '0; s1_b <= '0; s1_d <= '0; s1_c <= '0;
            s1_op <= '0; s1_cin <= 1'b0; s1_v <= 1'b0;
            s2_a <= '0; s2_pre <= '0; s2_c <= '0; s2_zsel <= '0;
            s2_psub <= 1'b0; s2_cin <= 1'b0; s2_v <= 1'b0;
            s3_c <= '0; s3_zsel <= '0; s3_psub <= 1'b0;
            s3_cin <= 1'b0; s3_v <= 1'b0;
            m_q <= '0; p_q <= '0; co_q <= 1'b0; ov_q <= 1'b0; ovf_q <= 1'b0;
        end else if (bus.CE) begin
            s1_a   <= bus.A;
            s1_b   <= bus.B;
            s1_d   <= bus.D;
            s1_c   <= bus.C;
            s1_op  <= bus.OPMODE;
            s1_cin <= bus.CARRYIN;
            s1_v   <= bus.IN_VALID;

            s2_a    <= s1_a;
            s2_pre  <= pre;
            s2_c    <= s1_c;
            s2_zsel <= s1_op[OP_ZSEL_HI:OP_ZSEL_LO];
            s2_psub <= s1_op[OP_POST_SUB];
            s2_cin  <= s1_cin;
            s2_v    <= s1_v;

            s3_c    <= s2_c;
            s3_zsel <= s2_zsel;
            s3_psub <= s2_psub;
            s3_cin  <= s2_cin;
            s3_v    <= s2_v;
            if (s2_v) begin
                m_q <= prod;
            end

            ov_q <= s3_v;
            if (bus.CLR) begin
                p_q   <= '0;
                ovf_q <= 1'b0;
            end else if (s3_v) begin
                p_q   <= pa_p;
                co_q  <= pa_carry;
                ovf_q <= ovf_q | pa_ovf;
            end
        end
    end

    assign bus.M         = m_q;
    assign bus.P         = p_q;
    assign bus.CARRYOUT  = co_q;
    assign bus.OUT_VALID = ov_q;
    assign bus.OVF       = ovf_q;
endmodule

// File: tb/tb_dsp_mac_pipe.sv
// tb/tb_dsp_mac_pipe.sv - directed vector bench for dsp_mac_pipe (wrap and saturating builds)
module tb_dsp_mac_pipe;
    import dsp_mac_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dsp_mac_pipe_if #(.AW(18), .BW(18), .PW(48)) bus0 ();
    dsp_mac_pipe_if #(.AW(18), .BW(18), .PW(48)) bus1 ();

    dsp_mac_pipe #(.AW(18), .BW(18), .PW(48), .SAT_EN(0)) dut (
        .CLK (clk), .RST (rst), .bus (bus0)
    );
    dsp_mac_pipe #(.AW(18), .BW(18), .PW(48), .SAT_EN(1)) dut_sat (
        .CLK (clk), .RST (rst), .bus (bus1)
    );

    assign bus1.CE       = bus0.CE;
    assign bus1.CLR      = bus0.CLR;
    assign bus1.IN_VALID = bus0.IN_VALID;
    assign bus1.OPMODE   = bus0.OPMODE;
    assign bus1.A        = bus0.A;
    assign bus1.B        = bus0.B;
    assign bus1.D        = bus0.D;
    assign bus1.C        = bus0.C;
    assign bus1.CARRYIN  = bus0.CARRYIN;

    typedef struct {
        logic [4:0]  op;
        logic [17:0] a, b, d;
        logic [47:0] c;
        logic        cin;
        logic [35:0] m;
        logic [47:0] p;
        logic        co;
    } vec_t;

    vec_t vt[8];
    int n_vec = 0;
    int n_err = 0;

    task automatic chk48(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk36(input string name, input logic [35:0] act, input logic [35:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] op, input logic [17:0] a,
                         input logic [17:0] b, input logic [17:0] d,
                         input logic [47:0] c, input logic cin);
        bus0.IN_VALID = v;
        bus0.OPMODE   = op;
        bus0.A        = a;
        bus0.B        = b;
        bus0.D        = d;
        bus0.C        = c;
        bus0.CARRYIN  = cin;
    endtask

    task automatic idle();
        drive(1'b0, 5'b0, 18'h0, 18'h0, 18'h0, 48'h0, 1'b0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk36({tag, " M"},        bus0.M, 36'h0);
        chk48({tag, " P"},        bus0.P, 48'h0);
        chk1 ({tag, " CARRYOUT"}, bus0.CARRYOUT, 1'b0);
        chk1 ({tag, " OUT_VALID"},bus0.OUT_VALID, 1'b0);
        chk1 ({tag, " OVF"},      bus0.OVF, 1'b0);
        chk36({tag, " sat M"},    bus1.M, 36'h0);
        chk48({tag, " sat P"},    bus1.P, 48'h0);
        chk1 ({tag, " sat OVF"},  bus1.OVF, 1'b0);
    endtask

    function automatic vec_t mk(input logic [4:0] op, input logic [17:0] a, input logic [17:0] b,
                                input logic [17:0] d, input logic [47:0] c, input logic cin,
                                input logic [35:0] m, input logic [47:0] p, input logic co);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.d = d; v.c = c; v.cin = cin;
        v.m = m; v.p = p; v.co = co;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = mk(5'b00101, 18'd20, 18'd10, 18'd25, 48'd350, 1'b0, 36'h2BC, 48'h41A, 1'b0);
        vt[1] = mk(5'b10100, 18'd5, 18'd6, 18'd0, 48'd0, 1'b0, 36'h1E, 48'hFFFFFFFFFFE2, 1'b1);
        vt[2] = mk(5'b10100, 18'd5, 18'd6, 18'd0, 48'd350, 1'b0, 36'h1E, 48'h140, 1'b0);
        vt[3] = mk(5'b00111, 18'h3FFFD, 18'd4, 18'd10, 48'd100, 1'b1, 36'hFFFFFFFEE, 48'h53, 1'b1);
        vt[4] = mk(5'b00000, 18'd7, 18'h3FFFE, 18'd0, 48'd99, 1'b0, 36'hFFFFFFFF2, 48'hFFFFFFFFFFF2, 1'b0);
        vt[5] = mk(5'b01100, 18'd2, 18'd3, 18'd0, 48'd77, 1'b1, 36'h6, 48'h7, 1'b0);
        vt[6] = mk(5'b00001, 18'd1, 18'd1, 18'h1FFFF, 48'd0, 1'b0, 36'hFFFFE0000, 48'hFFFFFFFE0000, 1'b0);
        vt[7] = mk(5'b10100, 18'd1, 18'd2, 18'd0, 48'd10, 1'b1, 36'h2, 48'h7, 1'b0);

        // Reset with random activity on every input
        rst = 1'b1;
        bus0.CE = 1'b1;
        bus0.CLR = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'($urandom), 18'($urandom), 18'($urandom), 18'($urandom),
                  48'({$urandom, $urandom}), 1'($urandom));
            tick();
        end
        chk_all_zero("reset");
        rst = 1'b0;
        idle();
        tick();

        // Single-sample vectors, each flushed before the next
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, vt[i].op, vt[i].a, vt[i].b, vt[i].d, vt[i].c, vt[i].cin);
            tick();
            idle();
            tick();
            tick();
            chk1 ($sformatf("vec%0d early OUT_VALID", i), bus0.OUT_VALID, 1'b0);
            chk36($sformatf("vec%0d M", i), bus0.M, vt[i].m);
            tick();
            chk48($sformatf("vec%0d P", i), bus0.P, vt[i].p);
            chk1 ($sformatf("vec%0d CARRYOUT", i), bus0.CARRYOUT, vt[i].co);
            chk1 ($sformatf("vec%0d OUT_VALID", i), bus0.OUT_VALID, 1'b1);
            chk48($sformatf("vec%0d sat P", i), bus1.P, vt[i].p);
            tick();
            chk1 ($sformatf("vec%0d OUT_VALID drop", i), bus0.OUT_VALID, 1'b0);
            chk48($sformatf("vec%0d P hold", i), bus0.P, vt[i].p);
        end

        // Accumulate chain: Z=0 then two back-to-back Z=P samples
        drive(1'b1, 5'b00000, 18'd5, 18'd6, 18'd0, 48'd0, 1'b0);
        tick();
        drive(1'b1, 5'b01000, 18'd5, 18'd6, 18'd0, 48'd0, 1'b0);
        tick();
        tick();
        idle();
        tick();
        chk48("acc P1", bus0.P, 48'd30);
        chk1 ("acc OV1", bus0.OUT_VALID, 1'b1);
        tick();
        chk48("acc P2", bus0.P, 48'd60);
        tick();
        chk48("acc P3", bus0.P, 48'd90);
        chk1 ("acc OV3", bus0.OUT_VALID, 1'b1);
        tick();
        chk1 ("acc OV end", bus0.OUT_VALID, 1'b0);
        bus0.CLR = 1'b1;
        tick();
        bus0.CLR = 1'b0;
        chk48("acc CLR P", bus0.P, 48'd0);

        // Stall for three cycles with two samples in flight
        drive(1'b1, 5'b00100, 18'd2, 18'd3, 18'd0, 48'd1, 1'b0);
        tick();
        drive(1'b1, 5'b00100, 18'd4, 18'd5, 18'd0, 48'd0, 1'b0);
        tick();
        idle();
        bus0.CE = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk48($sformatf("stall%0d P", i), bus0.P, 48'd0);
            chk1 ($sformatf("stall%0d OUT_VALID", i), bus0.OUT_VALID, 1'b0);
            chk36($sformatf("stall%0d M", i), bus0.M, 36'd30);
        end
        bus0.CE = 1'b1;
        tick();
        chk36("post-stall M1", bus0.M, 36'd6);
        chk1 ("post-stall OV early", bus0.OUT_VALID, 1'b0);
        tick();
        chk48("post-stall P1", bus0.P, 48'd7);
        chk1 ("post-stall OV1", bus0.OUT_VALID, 1'b1);
        tick();
        chk48("post-stall P2", bus0.P, 48'd20);
        chk36("post-stall M2", bus0.M, 36'd20);
        chk1 ("post-stall OV2", bus0.OUT_VALID, 1'b1);
        tick();
        chk1 ("post-stall OV end", bus0.OUT_VALID, 1'b0);

        // IN_VALID gap propagates as an OUT_VALID gap
        drive(1'b1, 5'b00100, 18'd1, 18'd1, 18'd0, 48'd0, 1'b0);
        tick();
        idle();
        tick();
        drive(1'b1, 5'b00100, 18'd1, 18'd2, 18'd0, 48'd0, 1'b0);
        tick();
        idle();
        tick();
        chk48("gap P1", bus0.P, 48'd1);
        chk1 ("gap OV1", bus0.OUT_VALID, 1'b1);
        tick();
        chk1 ("gap OV hole", bus0.OUT_VALID, 1'b0);
        chk48("gap P hold", bus0.P, 48'd1);
        tick();
        chk48("gap P2", bus0.P, 48'd2);
        chk1 ("gap OV2", bus0.OUT_VALID, 1'b1);
        tick();

        // Saturation vs wrap on the same positive overflow
        drive(1'b1, 5'b00100, 18'd1, 18'd1, 18'd0, 48'h7FFFFFFFFFFF, 1'b0);
        tick();
        drive(1'b1, 5'b00100, 18'd1, 18'd1, 18'd0, 48'd5, 1'b0);
        tick();
        idle();
        tick();
        tick();
        chk48("wrap P", bus0.P, 48'h800000000000);
        chk1 ("wrap OVF", bus0.OVF, 1'b0);
        chk1 ("wrap CARRYOUT", bus0.CARRYOUT, 1'b0);
        chk48("sat P", bus1.P, 48'h7FFFFFFFFFFF);
        chk1 ("sat OVF", bus1.OVF, 1'b1);
        tick();
        chk48("sat next P", bus1.P, 48'd6);
        chk1 ("sat OVF sticky", bus1.OVF, 1'b1);
        tick();
        chk1 ("sat OVF sticky idle", bus1.OVF, 1'b1);
        bus0.CLR = 1'b1;
        tick();
        bus0.CLR = 1'b0;
        chk1 ("sat OVF clr", bus1.OVF, 1'b0);
        chk48("sat P clr", bus1.P, 48'd0);

        // Asynchronous reset with samples in flight
        drive(1'b1, 5'b00100, 18'd3, 18'd3, 18'd0, 48'd0, 1'b0);
        tick();
        tick();
        tick();
        chk36("pre-rst M", bus0.M, 36'd9);
        idle();
        rst = 1'b1;
        #1;
        chk_all_zero("midrst");
        tick();
        rst = 1'b0;
        for (int i = 0; i < LAT + 1; i++) begin
            tick();
            chk1($sformatf("post-rst OV%0d", i), bus0.OUT_VALID, 1'b0);
        end
        chk48("post-rst P", bus0.P, 48'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
